// File: rtl/csr_file.sv
// rtl/csr_file.sv - machine-mode CSR file: trap state, 64-bit cycle/instret counters, external IRQ request
// Combinational read port with write forwarding; trap entry and mret update mstatus/mepc/mcause.
module csr_file #(
   parameter logic [31:0] HARTID    = 32'd0,
   parameter logic [31:0] MISA      = 32'h40000100,
   parameter logic [31:0] MTVEC_RST = 32'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        csr_rd,
   input  logic [11:0] csr_rd_addr,
   output logic [31:0] csr_rd_data,
   input  logic        csr_wr,
   input  logic [11:0] csr_wr_addr,
   input  logic [31:0] csr_wr_data,
   input  logic        instr_retired,
   input  logic        trap_in,
   input  logic [31:0] trap_pc,
   input  logic [31:0] trap_cause,
   input  logic        mret,
   input  logic        irq_ext,
   output logic [31:0] mtvec_out,
   output logic [31:0] mepc_out,
   output logic        irq_pending
);

   localparam logic [11:0] A_MSTATUS  = 12'h300;
   localparam logic [11:0] A_MISA     = 12'h301;
   localparam logic [11:0] A_MIE      = 12'h304;
   localparam logic [11:0] A_MTVEC    = 12'h305;
   localparam logic [11:0] A_MSCRATCH = 12'h340;
   localparam logic [11:0] A_MEPC     = 12'h341;
   localparam logic [11:0] A_MCAUSE   = 12'h342;
   localparam logic [11:0] A_MIP      = 12'h344;
   localparam logic [11:0] A_MCYCLE   = 12'hB00;
   localparam logic [11:0] A_MCYCLEH  = 12'hB80;
   localparam logic [11:0] A_MINSTR   = 12'hB02;
   localparam logic [11:0] A_MINSTRH  = 12'hB82;
   localparam logic [11:0] A_CYCLE    = 12'hC00;
   localparam logic [11:0] A_CYCLEH   = 12'hC80;
   localparam logic [11:0] A_INSTR    = 12'hC02;
   localparam logic [11:0] A_INSTRH   = 12'hC82;
   localparam logic [11:0] A_MHARTID  = 12'hF14;

   logic        mie_q, mie_d;
   logic        mpie_q, mpie_d;
   logic        meie_q, meie_d;
   logic        meip_q;
   logic [31:0] mtvec_q, mtvec_d;
   logic [31:0] mscratch_q, mscratch_d;
   logic [31:0] mepc_q, mepc_d;
   logic [31:0] mcause_q, mcause_d;
   logic [63:0] mcycle_q, mcycle_d;
   logic [63:0] minstret_q, minstret_d;
   logic        irq_pending_q, irq_pending_d;

   logic [31:0] mstatus_rd;
   logic [31:0] rd_val;
   logic [31:0] wr_val;
   logic        wr_ok;
   logic        wr_en;
   logic [63:0] mcycle_inc;
   logic [63:0] minstret_inc;

   assign mstatus_rd = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};

   always_comb begin
      rd_val = 32'h0;
      case (csr_rd_addr)
         A_MSTATUS:            rd_val = mstatus_rd;
         A_MISA:               rd_val = MISA;
         A_MIE:                rd_val = {20'b0, meie_q, 11'b0};
         A_MTVEC:              rd_val = mtvec_q;
         A_MSCRATCH:           rd_val = mscratch_q;
         A_MEPC:               rd_val = mepc_q;
         A_MCAUSE:             rd_val = mcause_q;
         A_MIP:                rd_val = {20'b0, meip_q, 11'b0};
         A_MCYCLE,  A_CYCLE:   rd_val = mcycle_q[31:0];
         A_MCYCLEH, A_CYCLEH:  rd_val = mcycle_q[63:32];
         A_MINSTR,  A_INSTR:   rd_val = minstret_q[31:0];
         A_MINSTRH, A_INSTRH:  rd_val = minstret_q[63:32];
         A_MHARTID:            rd_val = HARTID;
         default:              rd_val = 32'h0;
      endcase
   end

   // Legalized write value, shaped exactly as it would read back once committed.
   always_comb begin
      wr_ok  = 1'b0;
      wr_val = 32'h0;
      case (csr_wr_addr)
         A_MSTATUS: begin
            wr_ok  = 1'b1;
            wr_val = {19'b0, 2'b11, 3'b0, csr_wr_data[7], 3'b0, csr_wr_data[3], 3'b0};
         end
         A_MIE: begin
            wr_ok  = 1'b1;
            wr_val = {20'b0, csr_wr_data[11], 11'b0};
         end
         A_MTVEC, A_MEPC: begin
            wr_ok  = 1'b1;
            wr_val = {csr_wr_data[31:2], 2'b00};
         end
         A_MSCRATCH, A_MCAUSE, A_MCYCLE, A_MCYCLEH, A_MINSTR, A_MINSTRH: begin
            wr_ok  = 1'b1;
            wr_val = csr_wr_data;
         end
         default: begin
            wr_ok  = 1'b0;
            wr_val = 32'h0;
         end
      endcase
   end

   assign wr_en = csr_wr & wr_ok;

   always_comb begin
      csr_rd_data = 32'h0;
      if (csr_rd && !reset) begin
         if (wr_en && (csr_wr_addr == csr_rd_addr))
            csr_rd_data = wr_val;
         else
            csr_rd_data = rd_val;
      end
   end

   assign mcycle_inc   = mcycle_q + 64'd1;
   assign minstret_inc = minstret_q + {63'b0, instr_retired};

   always_comb begin
      mie_d      = mie_q;
      mpie_d     = mpie_q;
      meie_d     = meie_q;
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;

      // Priority: trap entry, then mret, then software write.
      if (trap_in) begin
         mpie_d   = mie_q;
         mie_d    = 1'b0;
         mepc_d   = {trap_pc[31:2], 2'b00};
         mcause_d = trap_cause;
      end else begin
         if (mret) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
         end else if (wr_en && csr_wr_addr == A_MSTATUS) begin
            mie_d  = wr_val[3];
            mpie_d = wr_val[7];
         end
         if (wr_en && csr_wr_addr == A_MEPC)   mepc_d   = wr_val;
         if (wr_en && csr_wr_addr == A_MCAUSE) mcause_d = wr_val;
      end

      if (wr_en && csr_wr_addr == A_MIE)      meie_d     = wr_val[11];
      if (wr_en && csr_wr_addr == A_MTVEC)    mtvec_d    = wr_val;
      if (wr_en && csr_wr_addr == A_MSCRATCH) mscratch_d = wr_val;

      // A write to one half freezes the other half for that cycle (no increment, no carry).
      if (wr_en && csr_wr_addr == A_MCYCLE)
         mcycle_d = {mcycle_q[63:32], wr_val};
      else if (wr_en && csr_wr_addr == A_MCYCLEH)
         mcycle_d = {wr_val, mcycle_q[31:0]};
      else
         mcycle_d = mcycle_inc;

      if (wr_en && csr_wr_addr == A_MINSTR)
         minstret_d = {minstret_q[63:32], wr_val};
      else if (wr_en && csr_wr_addr == A_MINSTRH)
         minstret_d = {wr_val, minstret_q[31:0]};
      else
         minstret_d = minstret_inc;

      irq_pending_d = mie_d & meie_d & meip_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mie_q         <= 1'b0;
         mpie_q        <= 1'b0;
         meie_q        <= 1'b0;
         meip_q        <= 1'b0;
         mtvec_q       <= MTVEC_RST;
         mscratch_q    <= 32'h0;
         mepc_q        <= 32'h0;
         mcause_q      <= 32'h0;
         mcycle_q      <= 64'h0;
         minstret_q    <= 64'h0;
         irq_pending_q <= 1'b0;
      end else begin
         mie_q         <= mie_d;
         mpie_q        <= mpie_d;
         meie_q        <= meie_d;
         meip_q        <= irq_ext;
         mtvec_q       <= mtvec_d;
         mscratch_q    <= mscratch_d;
         mepc_q        <= mepc_d;
         mcause_q      <= mcause_d;
         mcycle_q      <= mcycle_d;
         minstret_q    <= minstret_d;
         irq_pending_q <= irq_pending_d;
      end
   end

   assign mtvec_out   = mtvec_q;
   assign mepc_out    = mepc_q;
   assign irq_pending = irq_pending_q;

endmodule
